// File: rtl/idann_pkg.sv
// Shared types and helpers for the time-multiplexed neuron engine family.
package idann_pkg;

  // Sequencer states: wait for a request, accumulate one product per cycle, activate.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2
  } state_e;

  // Accumulator width that can hold bias + n full-range products with no overflow.
  function automatic int acc_width(input int n, input int xw, input int ww);
    return xw + ww + $clog2(n) + 2;
  endfunction

  // Clamp a signed value into the signed range of an out_w-bit result.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] res_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (value > max_v) begin
      res_v = max_v;
    end else if (value < min_v) begin
      res_v = min_v;
    end else begin
      res_v = value;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Combinational multiply-accumulate step: acc + zero-extended x times signed w.
module nn_mac_unit #(
  parameter int X_W   = 4,
  parameter int W_W   = 8,
  parameter int ACC_W = 16
) (
  input  logic               [X_W-1:0]   x_i,
  input  logic signed        [W_W-1:0]   w_i,
  input  logic signed        [ACC_W-1:0] acc_i,
  output logic signed        [ACC_W-1:0] acc_o
);

  localparam int PROD_W = X_W + W_W + 1;
  localparam int PAD_W  = ACC_W - PROD_W;

  logic signed [X_W:0]        x_ext_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;

  // x is unsigned, so a zero sign bit keeps the signed product exact; then sign-extend and add.
  always_comb begin
    x_ext_s    = {1'b0, x_i};
    prod_s     = x_ext_s * w_i;
    prod_ext_s = {{PAD_W{prod_s[PROD_W-1]}}, prod_s};
    acc_o      = acc_i + prod_ext_s;
  end

endmodule

// File: rtl/mac_neuron_seq.sv
// Time-multiplexed neuron: act(bias + sum x[i]*w[i]) with one shared multiplier,
// optional ReLU and signed saturation of the result to OUT_W bits.
module mac_neuron_seq
  import idann_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int X_W      = 4,
  parameter int W_W      = 8,
  parameter int OUT_W    = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [N_INPUTS*X_W-1:0]       x_i,
  input  logic [N_INPUTS*W_W-1:0]       w_i,
  input  logic signed [X_W+W_W-1:0]     bias_i,
  input  logic                          relu_en_i,
  output logic                          busy_o,
  output logic                          valid_o,
  output logic signed [OUT_W-1:0]       neuron_o,
  output logic                          sat_o
);

  localparam int ACC_W = acc_width(N_INPUTS, X_W, W_W);
  localparam int IDX_W = $clog2(N_INPUTS);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [N_INPUTS*X_W-1:0]      x_q, x_d;
  logic [N_INPUTS*W_W-1:0]      w_q, w_d;
  logic                         relu_q, relu_d;
  logic                         busy_q, busy_d;
  logic                         valid_q, valid_d;
  logic signed [OUT_W-1:0]      neuron_q, neuron_d;
  logic                         sat_q, sat_d;

  logic [X_W-1:0]               x_sel_s;
  logic signed [W_W-1:0]        w_sel_s;
  logic signed [ACC_W-1:0]      acc_next_s;
  logic signed [ACC_W-1:0]      relu_s;
  logic signed [63:0]           relu_wide_s;
  logic signed [63:0]           clamped_s;

  // Select the operand pair for the current product from the latched copies.
  always_comb begin
    x_sel_s = x_q[int'(idx_q)*X_W +: X_W];
    w_sel_s = w_q[int'(idx_q)*W_W +: W_W];
  end

  nn_mac_unit #(
    .X_W   (X_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .x_i   (x_sel_s),
    .w_i   (w_sel_s),
    .acc_i (acc_q),
    .acc_o (acc_next_s)
  );

  // Activation and saturation of the finished sum; ReLU zeroing is never a clamp.
  always_comb begin
    if (relu_q && acc_q[ACC_W-1]) begin
      relu_s = '0;
    end else begin
      relu_s = acc_q;
    end
    relu_wide_s = 64'(relu_s);
    clamped_s   = sat_clamp(relu_wide_s, OUT_W);
  end

  // Next-state logic: one MAC cycle per input pair, then a single ACT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (idx_q == IDX_W'(N_INPUTS - 1)) begin
          state_d = ACT;
        end else begin
          state_d = MAC;
        end
      end
      ACT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output updates per state; results only change on the ACT cycle.
  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    x_d      = x_q;
    w_d      = w_q;
    relu_d   = relu_q;
    neuron_d = neuron_q;
    sat_d    = sat_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d    = x_i;
          w_d    = w_i;
          relu_d = relu_en_i;
          acc_d  = ACC_W'(bias_i);
          idx_d  = '0;
        end else begin
          idx_d  = idx_q;
        end
      end
      MAC: begin
        acc_d = acc_next_s;
        idx_d = idx_q + IDX_W'(1);
      end
      ACT: begin
        neuron_d = clamped_s[OUT_W-1:0];
        sat_d    = (clamped_s != relu_wide_s);
        valid_d  = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset discards any partial result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      w_q      <= '0;
      relu_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      neuron_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      w_q      <= w_d;
      relu_q   <= relu_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      neuron_q <= neuron_d;
      sat_q    <= sat_d;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign neuron_o = neuron_q;
  assign sat_o    = sat_q;

endmodule
